// File: rtl/mcsr_pkg.sv
// Shared constants, types and helpers for the machine counter/HPM CSR block.
package mcsr_pkg;

    localparam int CNT_WIDTH_MIN  = 33;
    localparam int CNT_WIDTH_MAX  = 64;
    localparam int NUM_HPM_MAX    = 29;
    localparam int NUM_EVENTS_MAX = 31;

    localparam logic [11:0] ADDR_MCYCLE        = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET      = 12'hB02;
    localparam logic [11:0] ADDR_MHPMCNT3      = 12'hB03;
    localparam logic [11:0] ADDR_HI_OFFSET     = 12'h080;
    localparam logic [11:0] ADDR_MCOUNTINHIBIT = 12'h320;
    localparam logic [11:0] ADDR_MHPMEVENT3    = 12'h323;

    typedef logic [4:0] evt_sel_t;

    // Counter k: 0 = mcycle, 1 = minstret, 2+i = mhpmcounter(3+i).
    function automatic logic [11:0] cnt_lo_addr(input int k);
        return (k == 0) ? ADDR_MCYCLE : 12'(ADDR_MCYCLE + 12'(k + 1));
    endfunction

    function automatic logic [31:0] inhibit_mask(input int num_hpm);
        logic [31:0] m;
        m = 32'h0000_0005;
        for (int i = 0; i < num_hpm; i++) begin
            m[3 + i] = 1'b1;
        end
        return m;
    endfunction

    // Out-of-range selects collapse to 0, which never counts.
    function automatic evt_sel_t evt_warl(input logic [30:0] v, input int num_events);
        return (v > 31'(num_events)) ? 5'd0 : v[4:0];
    endfunction

endpackage

// File: rtl/mhpm_counter.sv
// One CNT_WIDTH-bit counter with 32-bit half writes, enable-gated increment and wrap flag.
module mhpm_counter
    import mcsr_pkg::*;
#(
    parameter int CNT_WIDTH = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    output logic [63:0] value,
    output logic        wrap
);

    logic [CNT_WIDTH-1:0] cnt_r;
    logic [CNT_WIDTH-1:0] cnt_next_s;
    logic [63:0]          cur_s;
    logic [63:0]          wr_val_s;

    assign cur_s = 64'(cnt_r);
    assign value = cur_s;

    // Next-value selection: a CSR write wins over the increment and is loaded as-is.
    always_comb begin
        wr_val_s   = cur_s;
        cnt_next_s = cnt_r;
        wrap       = 1'b0;
        if (wr_lo) begin
            wr_val_s[31:0] = wdata;
            cnt_next_s     = wr_val_s[CNT_WIDTH-1:0];
        end else if (wr_hi) begin
            wr_val_s[63:32] = wdata;
            cnt_next_s      = wr_val_s[CNT_WIDTH-1:0];
        end else if (inc) begin
            cnt_next_s = cnt_r + CNT_WIDTH'(1);
            wrap       = &cnt_r;
        end else begin
            cnt_next_s = cnt_r;
        end
    end

    // Counter state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CNT_WIDTH{1'b0}};
        end else begin
            cnt_r <= cnt_next_s;
        end
    end

endmodule

// File: rtl/mhpm_csr.sv
// Machine cycle/instret/HPM counter CSR block with zero-latency reads.
// Optional sticky overflow bits and interrupt: define MHPM_OVERFLOW_IRQ_EN.
module mhpm_csr
    import mcsr_pkg::*;
#(
    parameter int NUM_HPM    = 4,
    parameter int NUM_EVENTS = 8,
    parameter int CNT_WIDTH  = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  csr_read,
    input  logic                  csr_write,
    input  logic [11:0]           csr_address,
    input  logic [31:0]           csr_writedata,
    output logic [31:0]           csr_readdata,
    output logic                  csr_hit,
    input  logic                  i_retire,
    input  logic [NUM_EVENTS-1:0] i_events,
    output logic                  o_hpm_overflow_irq
);

    localparam int          NUM_CNT      = 2 + NUM_HPM;
    localparam int          HPM_N        = (NUM_HPM > 0) ? NUM_HPM : 1;
    localparam logic [31:0] INHIBIT_MASK = inhibit_mask(NUM_HPM);

    logic [31:0]        inhibit_r;
    evt_sel_t           evt_sel_r [HPM_N];
    logic [HPM_N-1:0]   evt_wr_s;
    logic [HPM_N-1:0]   of_s;
    logic [NUM_CNT-1:0] inc_s;
    logic [NUM_CNT-1:0] wr_lo_s;
    logic [NUM_CNT-1:0] wr_hi_s;
    logic [NUM_CNT-1:0] wrap_s;
    logic [63:0]        cnt_val_s [NUM_CNT];
    logic [31:0]        evt_ext_s;
    logic [31:0]        rd_s;

    // Bit 0 is a constant zero so that select 0 never counts.
    assign evt_ext_s = 32'({i_events, 1'b0});
    assign inc_s[0]  = ~inhibit_r[0];
    assign inc_s[1]  = i_retire & ~inhibit_r[2];

    for (genvar k = 0; k < NUM_CNT; k++) begin : g_cnt
        assign wr_lo_s[k] = csr_write && (csr_address == cnt_lo_addr(k));
        assign wr_hi_s[k] = csr_write && (csr_address == (cnt_lo_addr(k) | ADDR_HI_OFFSET));
        mhpm_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
            .clk   (clk),
            .rst   (rst),
            .inc   (inc_s[k]),
            .wr_lo (wr_lo_s[k]),
            .wr_hi (wr_hi_s[k]),
            .wdata (csr_writedata),
            .value (cnt_val_s[k]),
            .wrap  (wrap_s[k])
        );
    end

    for (genvar i = 0; i < NUM_HPM; i++) begin : g_hpm
        assign evt_wr_s[i]  = csr_write && (csr_address == 12'(ADDR_MHPMEVENT3 + 12'(i)));
        assign inc_s[2 + i] = evt_ext_s[evt_sel_r[i]] & ~inhibit_r[3 + i];
    end
    if (NUM_HPM == 0) begin : g_no_hpm
        assign evt_wr_s = 1'b0;
    end

    // Inhibit mask and event selects; new values steer increments from the next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            inhibit_r <= 32'h0000_0000;
            for (int i = 0; i < HPM_N; i++) begin
                evt_sel_r[i] <= 5'd0;
            end
        end else begin
            if (csr_write && (csr_address == ADDR_MCOUNTINHIBIT)) begin
                inhibit_r <= csr_writedata & INHIBIT_MASK;
            end
            for (int i = 0; i < NUM_HPM; i++) begin
                if (evt_wr_s[i]) begin
                    evt_sel_r[i] <= evt_warl(csr_writedata[30:0], NUM_EVENTS);
                end
            end
        end
    end

`ifdef MHPM_OVERFLOW_IRQ_EN
    logic [HPM_N-1:0] of_r;
    logic [HPM_N-1:0] of_next_s;
    logic             irq_r;

    // Sticky overflow: a wrap beats a same-cycle software clear.
    always_comb begin
        of_next_s = of_r;
        for (int i = 0; i < NUM_HPM; i++) begin
            if (wrap_s[2 + i]) begin
                of_next_s[i] = 1'b1;
            end else if (evt_wr_s[i]) begin
                of_next_s[i] = csr_writedata[31];
            end else begin
                of_next_s[i] = of_r[i];
            end
        end
    end

    // Overflow bits and the interrupt derived from their next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            of_r  <= {HPM_N{1'b0}};
            irq_r <= 1'b0;
        end else begin
            of_r  <= of_next_s;
            irq_r <= |of_next_s;
        end
    end

    assign of_s               = of_r;
    assign o_hpm_overflow_irq = irq_r;
`else
    assign of_s               = {HPM_N{1'b0}};
    assign o_hpm_overflow_irq = 1'b0;
`endif

    // Read mux: each matching register ORs in its value; no match yields zero.
    always_comb begin
        rd_s = 32'h0000_0000;
        for (int k = 0; k < NUM_CNT; k++) begin
            rd_s |= (csr_address == cnt_lo_addr(k)) ? cnt_val_s[k][31:0] : 32'h0000_0000;
            rd_s |= (csr_address == (cnt_lo_addr(k) | ADDR_HI_OFFSET)) ? cnt_val_s[k][63:32] : 32'h0000_0000;
        end
        rd_s |= (csr_address == ADDR_MCOUNTINHIBIT) ? inhibit_r : 32'h0000_0000;
        for (int i = 0; i < NUM_HPM; i++) begin
            rd_s |= (csr_address == 12'(ADDR_MHPMEVENT3 + 12'(i))) ?
                    {of_s[i], 26'h0, evt_sel_r[i]} : 32'h0000_0000;
        end
    end

    assign csr_readdata = csr_read ? rd_s : 32'h0000_0000;
    assign csr_hit      = (csr_address[11:5] == 7'b1011_000) ||
                          (csr_address[11:5] == 7'b1011_100) ||
                          (csr_address == ADDR_MCOUNTINHIBIT) ||
                          ((csr_address >= ADDR_MHPMEVENT3) && (csr_address <= 12'h33F));

endmodule

// File: tb/tb_mhpm_csr.sv
// Scoreboard bench for mhpm_csr: reads queue expected values, a negedge monitor compares.
module tb_mhpm_csr;

`ifdef MHPM_OVERFLOW_IRQ_EN
    localparam bit OF_EN = 1'b1;
`else
    localparam bit OF_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        csr_read, csr_write, csr_read2, csr_write2;
    logic [11:0] csr_address;
    logic [31:0] csr_writedata;
    logic [31:0] readdata, readdata2;
    logic        hit, hit2, irq, irq2;
    logic        i_retire;
    logic [7:0]  i_events;

    typedef struct {
        bit          d2;
        logic [31:0] data;
        bit          hit;
        bit          chk_irq;
        bit          irq;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    mhpm_csr #(.NUM_HPM(4), .NUM_EVENTS(8), .CNT_WIDTH(64)) dut (
        .clk(clk), .rst(rst), .csr_read(csr_read), .csr_write(csr_write),
        .csr_address(csr_address), .csr_writedata(csr_writedata),
        .csr_readdata(readdata), .csr_hit(hit), .i_retire(i_retire),
        .i_events(i_events), .o_hpm_overflow_irq(irq)
    );

    mhpm_csr #(.NUM_HPM(2), .NUM_EVENTS(8), .CNT_WIDTH(40)) dut2 (
        .clk(clk), .rst(rst), .csr_read(csr_read2), .csr_write(csr_write2),
        .csr_address(csr_address), .csr_writedata(csr_writedata),
        .csr_readdata(readdata2), .csr_hit(hit2), .i_retire(i_retire),
        .i_events(i_events), .o_hpm_overflow_irq(irq2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: whenever a read is presented, pop the oldest expectation and compare.
    always @(negedge clk) begin
        if (csr_read || csr_read2) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_read", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk({e.name, "_data"}, e.d2 ? readdata2 : readdata, e.data);
                chk({e.name, "_hit"}, {31'd0, e.d2 ? hit2 : hit}, {31'd0, e.hit});
                if (e.chk_irq) chk({e.name, "_irq"}, {31'd0, irq}, {31'd0, e.irq});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input bit d2, input logic [11:0] a, input logic [31:0] d);
        csr_address   = a;
        csr_writedata = d;
        if (d2) csr_write2 = 1'b1;
        else    csr_write  = 1'b1;
        tick();
        csr_write  = 1'b0;
        csr_write2 = 1'b0;
    endtask

    task automatic rd(input bit d2, input logic [11:0] a, input logic [31:0] exp,
                      input bit exp_hit, input bit chk_irq, input bit exp_irq, input string name);
        exp_t e;
        e.d2 = d2; e.data = exp; e.hit = exp_hit;
        e.chk_irq = chk_irq; e.irq = exp_irq; e.name = name;
        exp_q.push_back(e);
        csr_address = a;
        if (d2) csr_read2 = 1'b1;
        else    csr_read  = 1'b1;
        tick();
        csr_read  = 1'b0;
        csr_read2 = 1'b0;
    endtask

    initial begin
        rst = 1'b1; csr_read = 1'b0; csr_write = 1'b0; csr_read2 = 1'b0; csr_write2 = 1'b0;
        csr_address = 12'h000; csr_writedata = 32'h0; i_retire = 1'b0; i_events = 8'h00;
        repeat (3) tick();
        rd(0, 12'hB00, 32'd0, 1'b1, 1'b1, 1'b0, "reset_mcycle");
        rd(0, 12'h320, 32'd0, 1'b1, 1'b0, 1'b0, "reset_inhibit");
        rst = 1'b0;

        // Idle counting after reset, plus address decode corners.
        repeat (10) tick();
        rd(0, 12'hB00, 32'd10, 1'b1, 1'b0, 1'b0, "idle_mcycle");
        rd(0, 12'hB02, 32'd0,  1'b1, 1'b0, 1'b0, "idle_minstret");
        rd(0, 12'hB03, 32'd0,  1'b1, 1'b0, 1'b0, "idle_hpm3");
        rd(0, 12'hB80, 32'd0,  1'b1, 1'b0, 1'b0, "idle_mcycleh");
        rd(0, 12'hB01, 32'd0,  1'b1, 1'b0, 1'b0, "undecoded_b01");
        rd(0, 12'h000, 32'd0,  1'b0, 1'b0, 1'b0, "miss_000");
        rd(0, 12'h321, 32'd0,  1'b0, 1'b0, 1'b0, "miss_321");
        rd(0, 12'h33F, 32'd0,  1'b1, 1'b0, 1'b0, "unimpl_evt_33f");
        rd(0, 12'hB9F, 32'd0,  1'b1, 1'b0, 1'b0, "unimpl_cnt_b9f");

        // Event select 2 counts i_events[1] only; out-of-range select freezes.
        wr(0, 12'h323, 32'd2);
        rd(0, 12'h323, 32'd2, 1'b1, 1'b0, 1'b0, "evt3_sel2");
        i_events = 8'h01; repeat (3) tick();
        i_events = 8'h02; repeat (5) tick();
        i_events = 8'h00;
        rd(0, 12'hB03, 32'd5, 1'b1, 1'b0, 1'b0, "hpm3_count5");
        wr(0, 12'h323, 32'd40);
        rd(0, 12'h323, 32'd0, 1'b1, 1'b0, 1'b0, "evt3_warl40");
        i_events = 8'hFF; repeat (3) tick();
        i_events = 8'h00;
        rd(0, 12'hB03, 32'd5, 1'b1, 1'b0, 1'b0, "hpm3_frozen");
        rd(0, 12'hB04, 32'd0, 1'b1, 1'b0, 1'b0, "hpm4_sel0");
        wr(0, 12'h323, 32'd8);
        rd(0, 12'h323, 32'd8, 1'b1, 1'b0, 1'b0, "evt3_warl8");
        wr(0, 12'h323, 32'd9);
        rd(0, 12'h323, 32'd0, 1'b1, 1'b0, 1'b0, "evt3_warl9");

        // Low-half write has priority over increment; carry reaches the high half.
        rd(0, 12'hB80, 32'd0, 1'b1, 1'b0, 1'b0, "mcycleh_pre");
        wr(0, 12'hB00, 32'hFFFF_FFFF);
        rd(0, 12'hB00, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, "mcycle_loaded");
        rd(0, 12'hB00, 32'd0, 1'b1, 1'b0, 1'b0, "mcycle_carry_lo");
        rd(0, 12'hB80, 32'd1, 1'b1, 1'b0, 1'b0, "mcycle_carry_hi");
        wr(0, 12'hB82, 32'h1234_5678);
        rd(0, 12'hB82, 32'h1234_5678, 1'b1, 1'b0, 1'b0, "minstreth_write");
        rd(0, 12'hB02, 32'd0, 1'b1, 1'b0, 1'b0, "minstret_lo_kept");

        // mcountinhibit: writable mask, hold, and resume.
        wr(0, 12'h320, 32'hFFFF_FFFF);
        rd(0, 12'h320, 32'h0000_007D, 1'b1, 1'b0, 1'b0, "inhibit_mask");
        wr(0, 12'h320, 32'h0000_0005);
        i_retire = 1'b1;
        wr(0, 12'hB00, 32'd0);
        wr(0, 12'hB80, 32'd0);
        wr(0, 12'hB02, 32'd0);
        wr(0, 12'hB82, 32'd0);
        repeat (20) tick();
        rd(0, 12'hB00, 32'd0, 1'b1, 1'b0, 1'b0, "inhibit_mcycle_hold");
        rd(0, 12'hB02, 32'd0, 1'b1, 1'b0, 1'b0, "inhibit_minstret_hold");
        wr(0, 12'h320, 32'd0);
        repeat (3) tick();
        rd(0, 12'hB00, 32'd3, 1'b1, 1'b0, 1'b0, "resume_mcycle");
        rd(0, 12'hB02, 32'd4, 1'b1, 1'b0, 1'b0, "resume_minstret");
        i_retire = 1'b0;

        // hpm4 overflow: wraps to zero, sticky OF and IRQ (feature build only).
        wr(0, 12'h324, 32'd1);
        wr(0, 12'hB04, 32'hFFFF_FFFF);
        wr(0, 12'hB84, 32'hFFFF_FFFF);
        rd(0, 12'hB84, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, "hpm4_preload");
        i_events = 8'h01; tick();
        i_events = 8'h00;
        rd(0, 12'hB04, 32'd0, 1'b1, 1'b0, 1'b0, "hpm4_wrap_lo");
        rd(0, 12'hB84, 32'd0, 1'b1, 1'b0, 1'b0, "hpm4_wrap_hi");
        rd(0, 12'h324, {OF_EN, 31'd1}, 1'b1, 1'b1, OF_EN, "hpm4_of_set");
        wr(0, 12'h324, 32'h0000_0001);
        rd(0, 12'h324, 32'h0000_0001, 1'b1, 1'b1, 1'b0, "hpm4_of_clear");
        wr(0, 12'h324, 32'h8000_0001);
        rd(0, 12'h324, {OF_EN, 31'd1}, 1'b1, 1'b1, OF_EN, "hpm4_of_swset");
        wr(0, 12'h324, 32'h0000_0001);
        rd(0, 12'h324, 32'h0000_0001, 1'b1, 1'b1, 1'b0, "hpm4_of_clear2");

        // Narrow instance: unimplemented counter, and bits above CNT_WIDTH.
        wr(1, 12'hB85, 32'hFFFF_FFFF);
        rd(1, 12'hB85, 32'd0, 1'b1, 1'b0, 1'b0, "d2_unimpl_hpm5");
        wr(1, 12'hB83, 32'hFFFF_FFFF);
        rd(1, 12'hB83, 32'h0000_00FF, 1'b1, 1'b0, 1'b0, "d2_hpm3h_width40");
        rd(1, 12'h325, 32'd0, 1'b1, 1'b0, 1'b0, "d2_unimpl_evt5");
        wr(1, 12'h320, 32'hFFFF_FFFF);
        rd(1, 12'h320, 32'h0000_001D, 1'b1, 1'b0, 1'b0, "d2_inhibit_mask");

        // Reset asserted together with a write: reset wins.
        csr_address = 12'hB00; csr_writedata = 32'h55; csr_write = 1'b1; rst = 1'b1;
        tick();
        csr_write = 1'b0; rst = 1'b0;
        rd(0, 12'hB00, 32'd0, 1'b1, 1'b1, 1'b0, "rst_over_write");
        rd(0, 12'hB03, 32'd0, 1'b1, 1'b0, 1'b0, "rst_hpm3");
        rd(0, 12'h324, 32'd0, 1'b1, 1'b1, 1'b0, "rst_evt4");

        repeat (2) tick();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
